// File: rtl/top_level_pkg.sv
// top_level_pkg: shared FSM states, memory map and fixed-point constants for the Q8.8 to float16 converter.
package top_level_pkg;

    typedef enum logic [3:0] {
        S_WAIT,
        S_LOAD_LO,
        S_LOAD_HI,
        S_ABS,
        S_NORM,
        S_PACK,
        S_STORE_LO,
        S_STORE_HI,
        S_DONE
    } state_t;

    localparam logic [7:0] IN_LO  = 8'd0;
    localparam logic [7:0] IN_HI  = 8'd1;
    localparam logic [7:0] OUT_LO = 8'd2;
    localparam logic [7:0] OUT_HI = 8'd3;

    localparam int BIAS      = 15;
    localparam int FRAC_BITS = 8;

    localparam logic [1:0] WAIT_LAST = 2'd2;

    // Exponent of a normalized word whose MSB sits at bit 15 before any shifting.
    localparam logic [4:0] EXP_TOP = 5'(15 + BIAS - FRAC_BITS);

endpackage

// File: rtl/data_mem.sv
// data_mem: 256 x 8 single-port memory, combinational read, synchronous write, never cleared.
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem_core [0:255];

    always_ff @(posedge clk) begin
        if (we) mem_core[addr] <= wdata;
    end

    assign rdata = mem_core[addr];

endmodule

// File: rtl/top_level.sv
// top_level: converts the signed Q8.8 word at mem[1:0] to float16 at mem[3:2].
// Build option START_GATE_EN: hold after the wait period until start is sampled high.
module top_level
    import top_level_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] word_q, word_d;
    logic        sign_q, sign_d;
    logic [3:0]  shift_q, shift_d;
    logic [15:0] res_q, res_d;
    logic [7:0]  addr, wdata, rdata;
    logic        store, we, go;

`ifdef START_GATE_EN
    assign go = start;
`else
    logic start_unused;
    assign start_unused = start;
    assign go = 1'b1;
`endif

    data_mem data_mem1 (
        .clk  (clk),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        sign_d  = sign_q;
        shift_d = shift_q;
        res_d   = res_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = (cnt_q == WAIT_LAST) ? cnt_q : cnt_q + 2'd1;
                if (cnt_q == WAIT_LAST && go) state_d = S_LOAD_LO;
            end
            S_LOAD_LO: begin
                word_d  = {word_q[15:8], rdata};
                state_d = S_LOAD_HI;
            end
            S_LOAD_HI: begin
                word_d  = {rdata, word_q[7:0]};
                state_d = S_ABS;
            end
            S_ABS: begin
                sign_d  = word_q[15];
                word_d  = word_q[15] ? 16'(-word_q) : word_q;
                shift_d = 4'd0;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (word_q[15] || word_q == 16'd0) state_d = S_PACK;
                else begin
                    word_d  = word_q << 1;
                    shift_d = shift_q + 4'd1;
                end
            end
            S_PACK: begin
                res_d   = (word_q == 16'd0) ? 16'd0
                        : {sign_q, EXP_TOP - {1'b0, shift_q}, word_q[14:5]};
                state_d = S_STORE_LO;
            end
            S_STORE_LO: state_d = S_STORE_HI;
            S_STORE_HI: state_d = S_DONE;
            default:    state_d = S_DONE;
        endcase
    end

    assign addr  = state_q == S_LOAD_LO  ? IN_LO
                 : state_q == S_LOAD_HI  ? IN_HI
                 : state_q == S_STORE_LO ? OUT_LO
                 : state_q == S_STORE_HI ? OUT_HI : IN_LO;
    assign store = state_q == S_STORE_LO || state_q == S_STORE_HI;
    // A reset landing on a store cycle must not let the write through.
    assign we    = store && !reset;
    assign wdata = state_q == S_STORE_HI ? res_q[15:8] : res_q[7:0];
    assign done  = state_q == S_DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            cnt_q   <= 2'd0;
            word_q  <= 16'd0;
            sign_q  <= 1'b0;
            shift_q <= 4'd0;
            res_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            sign_q  <= sign_d;
            shift_q <= shift_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_top_level.sv
// tb_top_level: scoreboard bench for the Q8.8 to float16 converter; results checked when done rises.
module tb_top_level;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic done;

    top_level dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .done (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    string name_q[$];
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        logic [15:0] got, e;
        string n;
        if (done && !done_prev) begin
            got = {dut.data_mem1.mem_core[3], dut.data_mem1.mem_core[2]};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done got=%h", got);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL result_%s got=%h want=%h", n, got, e);
                end
            end
        end
        done_prev = done;
    end

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    task automatic preload(input logic [15:0] in);
        dut.data_mem1.mem_core[0] = in[7:0];
        dut.data_mem1.mem_core[1] = in[15:8];
    endtask

    task automatic wait_done(input string n);
        int cyc = 0;
`ifdef START_GATE_EN
        repeat (6) @(negedge clk);
        check({n, "_gate_hold"}, 32'(done), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`endif
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({n, "_latency_ok"}, 32'(cyc <= 30), 32'd1);
        repeat (3) @(negedge clk);
        check({n, "_done_hold"}, 32'(done), 32'd1);
    endtask

    task automatic run(input logic [15:0] in, input logic [15:0] e, input string n, input bit late);
        @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        check({n, "_done_low_in_reset"}, 32'(done), 32'd0);
        dut.data_mem1.mem_core[2] = 8'hAA;
        dut.data_mem1.mem_core[3] = 8'hAA;
        if (!late) preload(in);
        exp_q.push_back(e);
        name_q.push_back(n);
        reset = 1'b0;
        if (late) begin
            @(posedge clk);
            #1 preload(in);
        end
        wait_done(n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        run(16'h0000, 16'h0000, "zero", 1'b0);
        run(16'h0100, 16'h3C00, "one", 1'b0);
        run(16'h2000, 16'h5000, "x2000", 1'b1);
        run(16'hFF00, 16'hBC00, "neg_one", 1'b0);
        run(16'hFFFF, 16'h9C00, "neg_lsb", 1'b1);
        run(16'h8000, 16'hD800, "most_neg", 1'b0);
        run(16'h3C01, 16'h5380, "trunc", 1'b0);
        run(16'h7F00, 16'h57F0, "x7F00", 1'b1);
        run(16'h0001, 16'h1C00, "min_pos", 1'b0);

        // Abort a conversion deep in normalisation, then rerun on a new operand.
        @(posedge clk);
        reset = 1'b1;
        @(negedge clk);
        dut.data_mem1.mem_core[2] = 8'hAA;
        dut.data_mem1.mem_core[3] = 8'hAA;
        preload(16'h0001);
        reset = 1'b0;
`ifdef START_GATE_EN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`endif
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_done_low", 32'(done), 32'd0);
        preload(16'hFF00);
        exp_q.push_back(16'hBC00);
        name_q.push_back("rerun");
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_store", 32'({dut.data_mem1.mem_core[3], dut.data_mem1.mem_core[2]}), 32'hAAAA);
        check("rerun_done_low", 32'(done), 32'd0);
        wait_done("rerun");

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
